// File: rtl/mipi_lane_deinterleaver.sv
// mipi_lane_deinterleaver: de-interleaves raw D-PHY FIFO words into lane words on a framed valid/ready stream
module mipi_lane_deinterleaver #(
  parameter int NUM_LANES  = 2,
  parameter int LANE_BITS  = 16,
  parameter int RD_LAT     = 1,
  parameter int OBUF_DEPTH = 4,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             hs_burst_flag,
  input  logic                             fifo_empty,
  input  logic [NUM_LANES*LANE_BITS-1:0]   fifo_q,
  output logic                             fifo_rd_en,
  output logic                             fifo_reset,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_LANES*LANE_BITS-1:0]   out_data,
  output logic                             out_sop,
  output logic                             burst_done,
  output logic [CNT_W-1:0]                 burst_words,
  output logic                             busy
);
  localparam int W  = NUM_LANES * LANE_BITS;
  localparam int AW = $clog2(OBUF_DEPTH);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]        state;
  logic [RW-1:0]     rst_cnt;
  logic [RD_LAT-1:0] pipe;
  logic [W-1:0]      obuf [OBUF_DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [AW:0]       count;
  logic              sop_armed;
  logic [CNT_W-1:0]  word_cnt;
  logic [W-1:0]      lanes;
  logic [2:0]        in_flight;
  logic              push, pop, start, drained, rd_next;

  assign push       = pipe[RD_LAT-1];
  assign out_valid  = count != '0;
  assign pop        = out_valid && out_ready;
  assign out_data   = out_valid ? obuf[rp] : '0;
  assign out_sop    = out_valid && sop_armed;
  assign fifo_reset = state == FLUSH;
  assign busy       = state != IDLE;
  assign start      = state == IDLE && hs_burst_flag;
  assign drained    = state == DRAIN && fifo_empty && in_flight == '0 && !fifo_rd_en && count == '0;
  assign rd_next    = (state == RUN || state == DRAIN) && !fifo_empty &&
                      (32'(count) + 32'(in_flight) + 32'(fifo_rd_en) < 32'(OBUF_DEPTH));

  // lane l bit b comes from FIFO bit b*NUM_LANES+l
  always_comb begin
    lanes = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int b = 0; b < LANE_BITS; b++)
        lanes[l*LANE_BITS+b] = fifo_q[b*NUM_LANES+l];
  end

  // reads still travelling through the FIFO read latency
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++)
      in_flight = in_flight + 3'(pipe[i]);
  end

  // burst sequencing: flush the FIFO, wait for a burst, read it, drain it
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state   <= FLUSH;
      rst_cnt <= '0;
    end else begin
      rst_cnt <= state == FLUSH ? rst_cnt + 1'b1 : '0;
      case (state)
        IDLE:    if (hs_burst_flag) state <= RUN;
        RUN:     if (!hs_burst_flag) state <= DRAIN;
        DRAIN:   if (drained) state <= FLUSH;
        default: if (rst_cnt == RW'(RST_CYCLES - 1)) state <= IDLE;
      endcase
    end

  // credit-based read issue, latency tracking, buffer pointers and burst framing
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      fifo_rd_en  <= 1'b0;
      pipe        <= '0;
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      sop_armed   <= 1'b0;
      word_cnt    <= '0;
      burst_done  <= 1'b0;
      burst_words <= '0;
    end else begin
      fifo_rd_en  <= rd_next;
      pipe        <= RD_LAT'({pipe, fifo_rd_en});
      wp          <= push ? wp + 1'b1 : wp;
      rp          <= pop ? rp + 1'b1 : rp;
      count       <= count + (AW+1)'(push) - (AW+1)'(pop);
      sop_armed   <= start ? 1'b1 : pop ? 1'b0 : sop_armed;
      word_cnt    <= start ? '0 : (pop && word_cnt != '1) ? word_cnt + 1'b1 : word_cnt;
      burst_done  <= drained;
      burst_words <= drained ? word_cnt : burst_words;
    end

  // buffer storage, written as each read returns
  always_ff @(posedge sys_clk)
    if (push) obuf[wp] <= lanes;
endmodule

// File: tb/tb_mipi_lane_deinterleaver.sv
// tb_mipi_lane_deinterleaver: directed scoreboard bench for the lane de-interleaver
module tb_mipi_lane_deinterleaver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_rst = 1'b1;
  logic        hs_a = 1'b0, ordy_a = 1'b1, rd_en_a, freset_a, ov_a, sop_a, bd_a, busy_a;
  logic [31:0] fifo_q_a = '0, od_a;
  logic [15:0] bw_a;
  logic        fifo_empty_a;
  logic        hs_b = 1'b0, ordy_b = 1'b1, rd_en_b, freset_b, ov_b, sop_b, bd_b, busy_b;
  logic [31:0] fifo_q_b = '0, q1_b = '0, od_b;
  logic [15:0] bw_b;
  logic        fifo_empty_b;

  logic [31:0] mem_a[$], mem_b[$], exp_a[$], exp_b[$];
  int pushed_a = 0, popped_a = 0, pushed_b = 0, popped_b = 0;
  int n_chk = 0, n_err = 0, cyc = 0;
  int rmode_a = 0, reads_a = 0, pops_a = 0, max_out = 0, bd_cnt = 0, t_rd = -1, t_v = -1;
  logic [15:0] bw_got = '0;
  logic first_a = 1'b0, first_b = 1'b0;

  mipi_lane_deinterleaver dut (
    .sys_clk(clk), .sys_rst(sys_rst), .hs_burst_flag(hs_a), .fifo_empty(fifo_empty_a),
    .fifo_q(fifo_q_a), .fifo_rd_en(rd_en_a), .fifo_reset(freset_a), .out_valid(ov_a),
    .out_ready(ordy_a), .out_data(od_a), .out_sop(sop_a), .burst_done(bd_a),
    .burst_words(bw_a), .busy(busy_a));

  mipi_lane_deinterleaver #(.NUM_LANES(4), .LANE_BITS(8), .RD_LAT(2)) dut4 (
    .sys_clk(clk), .sys_rst(sys_rst), .hs_burst_flag(hs_b), .fifo_empty(fifo_empty_b),
    .fifo_q(fifo_q_b), .fifo_rd_en(rd_en_b), .fifo_reset(freset_b), .out_valid(ov_b),
    .out_ready(ordy_b), .out_data(od_b), .out_sop(sop_b), .burst_done(bd_b),
    .burst_words(bw_b), .busy(busy_b));

  // raw FIFO models: the empty flag already accounts for a read strobe in progress
  assign fifo_empty_a = (pushed_a - popped_a - int'(rd_en_a)) <= 0;
  assign fifo_empty_b = (pushed_b - popped_b - int'(rd_en_b)) <= 0;

  always @(posedge clk)
    if (freset_a) popped_a <= pushed_a;
    else if (rd_en_a && popped_a < pushed_a) begin
      fifo_q_a <= mem_a[popped_a];
      popped_a <= popped_a + 1;
    end

  always @(posedge clk) begin
    fifo_q_b <= q1_b;
    if (freset_b) popped_b <= pushed_b;
    else if (rd_en_b && popped_b < pushed_b) begin
      q1_b     <= mem_b[popped_b];
      popped_b <= popped_b + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] deint2(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 16; b++)
      for (int l = 0; l < 2; l++)
        r[l*16+b] = w[b*2+l];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out_a();
    if (ov_a) begin
      check("a_valid_expected", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) begin
        check("a_data", od_a, exp_a[0]);
        check("a_sop", sop_a, first_a);
        if (ordy_a) begin
          void'(exp_a.pop_front());
          first_a = 1'b0;
          pops_a++;
        end
      end
    end else begin
      check("a_idle_data", od_a, 0);
      check("a_idle_sop", sop_a, 0);
    end
  endtask

  task automatic check_out_b();
    if (ov_b) begin
      check("b_valid_expected", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) begin
        check("b_data", od_b, exp_b[0]);
        check("b_sop", sop_b, first_b);
        if (ordy_b) begin
          void'(exp_b.pop_front());
          first_b = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    ordy_a = (rmode_a == 0) || (rmode_a == 1 && cyc % 3 == 0);
    check_out_a();
    check_out_b();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_en_a) reads_a++;
    if (reads_a - pops_a > max_out) max_out = reads_a - pops_a;
    check("a_outstanding_le_depth", (reads_a - pops_a) <= 4, 1);
    if (bd_a) begin
      bd_cnt++;
      bw_got = bw_a;
    end
    if (rd_en_b && t_rd < 0) t_rd = cyc;
    if (ov_b && t_v < 0) t_v = cyc;
  endtask

  task automatic wait_idle_a();
    int k = 0;
    while (busy_a && k < 100) begin
      step();
      k++;
    end
    check("a_idle_reached", busy_a, 0);
  endtask

  task automatic burst_a(input int n, input int mode, input logic [31:0] w0, input logic [31:0] e0);
    int k;
    wait_idle_a();
    rmode_a = mode;
    reads_a = 0;
    pops_a  = 0;
    max_out = 0;
    bd_cnt  = 0;
    first_a = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = i == 0 ? w0 : $urandom();
      mem_a.push_back(w);
      pushed_a++;
      exp_a.push_back(i == 0 ? e0 : deint2(w));
    end
    hs_a = 1'b1;
    repeat (3) step();
    hs_a = 1'b0;
    k = 0;
    while (bd_cnt == 0 && k < 300) begin
      step();
      k++;
    end
    check("burst_done_seen", bd_cnt, 1);
    k = 0;
    while (freset_a && k < 10) begin
      step();
      k++;
    end
    check("fifo_reset_cycles", k, 4);
    check("burst_words", bw_got, n);
    check("pop_count", pops_a, n);
    check("scoreboard_empty", exp_a.size(), 0);
    repeat (3) step();
    check("single_burst_done", bd_cnt, 1);
    if (mode == 1) check("max_outstanding", max_out, 4);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_fifo_reset", freset_a, 1);
    check("rst_rd_en", rd_en_a, 0);
    check("rst_out_valid", ov_a, 0);
    check("rst_out_data", od_a, 0);
    check("rst_sop", sop_a, 0);
    check("rst_burst_done", bd_a, 0);
    check("rst_burst_words", bw_a, 0);
    check("rst_busy", busy_a, 1);
    sys_rst = 1'b0;

    burst_a(1, 0, 32'h5555_5555, 32'h0000_FFFF);

    begin
      int k = 0;
      logic [31:0] wv [4] = '{32'h0000_000F, 32'h0000_0020, 32'h8000_0000, 32'hF000_0000};
      logic [31:0] ev [4] = '{32'h0101_0101, 32'h0000_0200, 32'h8000_0000, 32'h8080_8080};
      first_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
        mem_b.push_back(wv[i]);
        pushed_b++;
        exp_b.push_back(ev[i]);
      end
      hs_b = 1'b1;
      repeat (2) step();
      hs_b = 1'b0;
      while ((exp_b.size() != 0 || busy_b) && k < 60) begin
        step();
        k++;
      end
      check("b_read_to_valid", t_v - t_rd, 3);
      check("b_scoreboard_empty", exp_b.size(), 0);
      check("b_burst_words", bw_b, 4);
    end

    burst_a(10, 0, 32'hAAAA_5555, 32'hFF00_00FF);
    burst_a(10, 1, 32'h1234_5678, deint2(32'h1234_5678));
    burst_a(0, 0, 32'h0, 32'h0);

    wait_idle_a();
    rmode_a = 2;
    reads_a = 0;
    pops_a  = 0;
    first_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      w = $urandom();
      mem_a.push_back(w);
      pushed_a++;
      exp_a.push_back(deint2(w));
    end
    hs_a = 1'b1;
    repeat (8) step();
    check("buffered_valid", ov_a, 1);
    sys_rst = 1'b1;
    hs_a = 1'b0;
    bd_cnt = 0;
    step();
    check("midrst_out_valid", ov_a, 0);
    check("midrst_fifo_reset", freset_a, 1);
    check("midrst_burst_done", bd_a, 0);
    sys_rst = 1'b0;
    exp_a.delete();
    repeat (12) step();
    check("midrst_no_burst_done", bd_cnt, 0);
    check("midrst_back_idle", busy_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
